bbot_uart_rx: RTL
=================

BBOT_UART_RX -- requirements
Module: bbot_uart_rx

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200 baud); legal values are 4 to 65535.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port rx_in, input, 1 bit: serial line from one routed RX output of the UART smart mux; idle level is 1.
REQ-005 The block SHALL have port rx_ready, input, 1 bit: the consumer accepts rx_data in any cycle where rx_valid and rx_ready are both 1.
REQ-006 The block SHALL have port rx_data, output, 8 bits: received byte.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unaccepted byte.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-009 The block SHALL have port overrun, output, 1 bit: sticky flag meaning a completed byte was dropped.
REQ-010 The block SHALL have port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer whose flops reset to 1; all FSM decisions SHALL use the synchronized value (rx_s).
REQ-012 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, optional parity (see Configuration), and 1 stop bit (1).
REQ-013 The FSM states SHALL be IDLE, START, DATA, PARITY (present only with the macro), STOP and WAIT_IDLE.
REQ-014 IDLE -> START SHALL occur when rx_s = 0; the baud counter clears to 0.
REQ-015 In START, at counter = CLKS_PER_BIT/2 - 1 (integer division), rx_s = 0 SHALL go to DATA with the counter cleared; rx_s = 1 is a glitch and SHALL return to IDLE with no flag raised.
REQ-016 In DATA, a bit SHALL be sampled each time counter = CLKS_PER_BIT - 1, then the counter clears; a 3-bit index counts bits 0..7, and after bit 7 the FSM goes to PARITY or STOP.
REQ-017 In STOP, a sample of rx_s = 1 SHALL complete the frame and return to IDLE; a sample of 0 SHALL pulse frame_err for one cycle, discard the byte, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL return to IDLE on the first cycle in which rx_s = 1 (break or line-low handling).
REQ-019 On completion, if rx_valid = 0, or rx_valid = 1 and rx_ready = 1 in the same cycle, the new byte SHALL load into rx_data and rx_valid SHALL be 1 on the next cycle, giving one cycle of latency after the stop-bit sample.
REQ-020 On completion with rx_valid = 1 and rx_ready = 0, the new byte SHALL be dropped, rx_data SHALL remain unchanged, and overrun SHALL set.
REQ-021 An accepted handshake with no simultaneous completion SHALL clear rx_valid on the next cycle.
REQ-022 overrun SHALL clear on the next accepted handshake, unless a drop occurs in that same cycle, in which case it stays set.
REQ-023 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never count past CLKS_PER_BIT - 1.
REQ-024 rx_data SHALL stay stable while rx_valid = 1.

Reset
REQ-025 While reset = 1 at a clock edge, the block SHALL set: FSM to IDLE, counters to 0, synchronizer to 1, rx_data to 0x00, rx_valid to 0, frame_err to 0, overrun to 0, busy to 0.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no flag raised and no byte delivered.

Configuration
REQ-027 When the macro BBOT_UART_RX_PARITY_EN is defined, the block SHALL include the PARITY state, which samples one even-parity bit after data bit 7.
REQ-028 With BBOT_UART_RX_PARITY_EN defined, a parity mismatch SHALL still run STOP, then pulse frame_err and discard the byte regardless of the stop bit value.
REQ-029 When BBOT_UART_RX_PARITY_EN is undefined, there SHALL be no PARITY state and the frame SHALL be 10 bits.

Verification (CLKS_PER_BIT = 16)
REQ-030 Bench scenario, basic receive: rx_ready = 1, send 0xA5 -> rx_data = 0xA5, rx_valid high for 1 cycle, frame_err = 0, overrun = 0.
REQ-031 Bench scenario, start-bit glitch: rx_in low for 4 cycles, then high -> busy returns to 0, with no rx_valid and no frame_err.
REQ-032 Bench scenario, bad stop bit: send 0x3C with stop bit = 0 and the line held low for 40 cycles -> one frame_err pulse, no rx_valid, and IDLE only after the line returns high.
REQ-033 Bench scenario, overrun: rx_ready = 0, send 0x11 then 0x22 -> rx_data = 0x11 and overrun = 1; then raise rx_ready for one cycle -> rx_valid = 0 and overrun = 0.
REQ-034 Bench scenario, reset mid-frame: assert reset during data bit 4 of 0xFF, then send 0x5A -> only 0x5A is delivered.
REQ-035 Bench scenario, parity (macro defined): send 0x07 with parity bit 1 -> rx_data = 0x07 delivered; send 0x07 with parity bit 0 -> frame_err pulse and no rx_valid.

Source files
------------

// File: rtl/bbot_uart_rx.sv
// bbot_uart_rx: 8-bit UART receiver with a ready/valid output and sticky overrun.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1).
// Define BBOT_UART_RX_PARITY_EN to add the even-parity bit after data bit 7.
module bbot_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef BBOT_UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            done;
    logic            reject;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            overrun_q;
`ifdef BBOT_UART_RX_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clock) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx_in};
    end

    // Frame FSM, baud counter, bit index and shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef BBOT_UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef BBOT_UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Next-state logic; done/reject are single-cycle strobes at the stop-bit sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done      = 1'b0;
        reject    = 1'b0;
`ifdef BBOT_UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
`ifdef BBOT_UART_RX_PARITY_EN
                par_err_d = 1'b0;
`endif
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    // Line back high at mid-start means a glitch: drop silently.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef BBOT_UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef BBOT_UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == FullCnt) begin
                    cnt_d     = '0;
                    par_err_d = rx_s ^ (^shift_q);
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (cnt_q == FullCnt) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        reject  = 1'b1;
                        state_d = StWaitIdle;
                    end else begin
                        state_d = StIdle;
`ifdef BBOT_UART_RX_PARITY_EN
                        if (par_err_q) reject = 1'b1;
                        else           done   = 1'b1;
`else
                        done = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output holding register with ready/valid handshake and sticky overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= reject;
            if (done && (!rx_valid_q || rx_ready)) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            // A drop in the same cycle as an accept keeps the flag set.
            if (done && rx_valid_q && !rx_ready)  overrun_q <= 1'b1;
            else if (rx_valid_q && rx_ready)      overrun_q <= 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule
